// File: rtl/mem_access_stage.sv
// MIPS MEM stage with MEM/WB pipeline register: byte-lane stores, synchronous
// read capture, and load extraction/extension feeding write_back.
module mem_access_stage #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        in_reg_wr_en,
   input  logic        in_mem_to_reg,
   input  logic        in_mem_wr_en,
   input  logic [1:0]  in_mem_size,
   input  logic        in_load_signed,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_wr_data,
   input  logic [4:0]  in_reg_wr_addr,
   output logic        reg_wr_en,
   output logic        mem_to_reg_wr,
   output logic [31:0] alu_result,
   output logic [31:0] mem_rd_data,
   output logic [4:0]  reg_wr_addr,
   output logic        misalign_err
);

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_off;
   logic              misaligned;
   logic              advance;
   logic              do_store;
   logic [3:0]        lane_en;
   logic [31:0]       lane_data;

   // Registered read side: captured word plus what is needed to extract from it.
   logic [31:0]       rd_word;
   logic [1:0]        rd_off;
   logic [1:0]        rd_size;
   logic              rd_signed;

   logic              unused_addr_bits;

   assign word_idx         = in_alu_result[ADDR_W+1:2];
   assign byte_off         = in_alu_result[1:0];
   assign unused_addr_bits = ^in_alu_result[31:ADDR_W+2];

   assign misaligned = ((in_mem_size == 2'b01) & byte_off[0]) |
                       (in_mem_size[1] & (byte_off != 2'b00));
   assign advance    = ~stall & ~flush;
   assign do_store   = advance & in_mem_wr_en & ~misaligned;

   always_comb begin
      lane_en   = '0;
      lane_data = in_wr_data;
      unique case (in_mem_size)
         2'b00: begin
            lane_en[byte_off] = 1'b1;
            lane_data         = {4{in_wr_data[7:0]}};
         end
         2'b01: begin
            lane_en   = byte_off[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{in_wr_data[15:0]}};
         end
         default: begin
            lane_en   = '1;
            lane_data = in_wr_data;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (do_store && lane_en[i]) begin
            mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

   // A flush zeroes the read side too, so the extracted bubble data is 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr_en     <= 1'b0;
         mem_to_reg_wr <= 1'b0;
         alu_result    <= '0;
         reg_wr_addr   <= '0;
         misalign_err  <= 1'b0;
         rd_word       <= '0;
         rd_off        <= '0;
         rd_size       <= '0;
         rd_signed     <= 1'b0;
      end else if (flush) begin
         reg_wr_en     <= 1'b0;
         mem_to_reg_wr <= 1'b0;
         alu_result    <= '0;
         reg_wr_addr   <= '0;
         misalign_err  <= 1'b0;
         rd_word       <= '0;
         rd_off        <= '0;
         rd_size       <= '0;
         rd_signed     <= 1'b0;
      end else if (!stall) begin
         reg_wr_en     <= in_reg_wr_en & ~(in_mem_to_reg & misaligned);
         mem_to_reg_wr <= in_mem_to_reg;
         alu_result    <= in_alu_result;
         reg_wr_addr   <= in_reg_wr_addr;
         misalign_err  <= misaligned & (in_mem_wr_en | in_mem_to_reg);
         rd_word       <= mem[word_idx];
         rd_off        <= byte_off;
         rd_size       <= in_mem_size;
         rd_signed     <= in_load_signed;
      end
   end

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      rd_byte = '0;
      unique case (rd_off)
         2'd0: rd_byte = rd_word[7:0];
         2'd1: rd_byte = rd_word[15:8];
         2'd2: rd_byte = rd_word[23:16];
         default: rd_byte = rd_word[31:24];
      endcase
      rd_half = rd_off[1] ? rd_word[31:16] : rd_word[15:0];
   end

   always_comb begin
      mem_rd_data = rd_word;
      unique case (rd_size)
         2'b00: mem_rd_data = {{24{rd_signed & rd_byte[7]}}, rd_byte};
         2'b01: mem_rd_data = {{16{rd_signed & rd_half[15]}}, rd_half};
         default: mem_rd_data = rd_word;
      endcase
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single-cycle vectors with
// hand-computed WB outputs, plus a hand-written reset-in-flight sequence.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush;
   logic        in_reg_wr_en, in_mem_to_reg, in_mem_wr_en;
   logic [1:0]  in_mem_size;
   logic        in_load_signed;
   logic [31:0] in_alu_result, in_wr_data;
   logic [4:0]  in_reg_wr_addr;
   logic        reg_wr_en, mem_to_reg_wr, misalign_err;
   logic [31:0] alu_result, mem_rd_data;
   logic [4:0]  reg_wr_addr;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.DEPTH(256), .ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .in_reg_wr_en(in_reg_wr_en), .in_mem_to_reg(in_mem_to_reg),
      .in_mem_wr_en(in_mem_wr_en), .in_mem_size(in_mem_size),
      .in_load_signed(in_load_signed), .in_alu_result(in_alu_result),
      .in_wr_data(in_wr_data), .in_reg_wr_addr(in_reg_wr_addr),
      .reg_wr_en(reg_wr_en), .mem_to_reg_wr(mem_to_reg_wr),
      .alu_result(alu_result), .mem_rd_data(mem_rd_data),
      .reg_wr_addr(reg_wr_addr), .misalign_err(misalign_err)
   );

   typedef struct {
      logic        stall, flush, rwe, m2r, mwe;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr, wdata;
      logic [4:0]  waddr;
      logic        e_rwe, e_m2r, e_mis;
      logic [31:0] e_alu;
      logic        chk_rd;
      logic [31:0] e_rd;
      logic [4:0]  e_waddr;
   } vec_t;

   vec_t vecs[$];

   task automatic v(input logic st, input logic fl, input logic rwe, input logic m2r,
                    input logic mwe, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wa,
                    input logic e_rwe, input logic e_m2r, input logic e_mis,
                    input logic [31:0] e_alu, input logic c_rd, input logic [31:0] e_rd,
                    input logic [4:0] e_wa);
      vec_t t;
      t.stall = st; t.flush = fl; t.rwe = rwe; t.m2r = m2r; t.mwe = mwe;
      t.size = sz; t.sgn = sg; t.addr = a; t.wdata = wd; t.waddr = wa;
      t.e_rwe = e_rwe; t.e_m2r = e_m2r; t.e_mis = e_mis; t.e_alu = e_alu;
      t.chk_rd = c_rd; t.e_rd = e_rd; t.e_waddr = e_wa;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      stall = t.stall; flush = t.flush;
      in_reg_wr_en = t.rwe; in_mem_to_reg = t.m2r; in_mem_wr_en = t.mwe;
      in_mem_size = t.size; in_load_signed = t.sgn;
      in_alu_result = t.addr; in_wr_data = t.wdata; in_reg_wr_addr = t.waddr;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".reg_wr_en"},     {31'd0, reg_wr_en},     32'd0);
      chk({tag, ".mem_to_reg_wr"}, {31'd0, mem_to_reg_wr}, 32'd0);
      chk({tag, ".misalign_err"},  {31'd0, misalign_err},  32'd0);
      chk({tag, ".alu_result"},    alu_result,             32'd0);
      chk({tag, ".mem_rd_data"},   mem_rd_data,            32'd0);
      chk({tag, ".reg_wr_addr"},   {27'd0, reg_wr_addr},   32'd0);
   endtask

   initial begin
      vec_t idle;
      rst_n = 1'b0;
      idle = '{default: '0};
      drive(idle);

      //  st fl rwe m2r mwe sz sg  addr      wdata        wa | rwe m2r mis alu     crd rd            wa
      v(0,0, 0,0,1, 2'd2,0, 32'h010, 32'hDEADBEEF, 5'd0,  0,0,0, 32'h010, 0, 32'h0,        5'd0);
      v(0,0, 1,1,0, 2'd0,1, 32'h013, 32'h0,        5'd2,  1,1,0, 32'h013, 1, 32'hFFFFFFDE, 5'd2);
      v(0,0, 1,1,0, 2'd0,0, 32'h012, 32'h0,        5'd3,  1,1,0, 32'h012, 1, 32'h000000AD, 5'd3);
      v(0,0, 1,1,0, 2'd1,1, 32'h012, 32'h0,        5'd4,  1,1,0, 32'h012, 1, 32'hFFFFDEAD, 5'd4);
      v(0,0, 1,1,0, 2'd1,0, 32'h010, 32'h0,        5'd5,  1,1,0, 32'h010, 1, 32'h0000BEEF, 5'd5);
      v(0,0, 1,1,0, 2'd2,0, 32'h010, 32'h0,        5'd6,  1,1,0, 32'h010, 1, 32'hDEADBEEF, 5'd6);
      v(0,0, 0,0,1, 2'd0,0, 32'h011, 32'h00000055, 5'd0,  0,0,0, 32'h011, 0, 32'h0,        5'd0);
      v(0,0, 0,0,1, 2'd1,0, 32'h012, 32'h00001234, 5'd0,  0,0,0, 32'h012, 0, 32'h0,        5'd0);
      v(0,0, 1,1,0, 2'd2,0, 32'h010, 32'h0,        5'd7,  1,1,0, 32'h010, 1, 32'h123455EF, 5'd7);
      v(0,0, 0,0,1, 2'd2,0, 32'h020, 32'hCAFEF00D, 5'd0,  0,0,0, 32'h020, 0, 32'h0,        5'd0);
      // misaligned lw, then R-type: error flag must drop after one cycle
      v(0,0, 1,1,0, 2'd2,0, 32'h022, 32'h0,        5'd8,  0,1,1, 32'h022, 0, 32'h0,        5'd8);
      v(0,0, 1,0,0, 2'd2,0, 32'h007, 32'h0,        5'd9,  1,0,0, 32'h007, 0, 32'h0,        5'd9);
      v(0,0, 0,0,1, 2'd1,0, 32'h021, 32'h0000FFFF, 5'd0,  0,0,1, 32'h021, 0, 32'h0,        5'd0);
      v(0,0, 1,1,0, 2'd2,0, 32'h020, 32'h0,        5'd10, 1,1,0, 32'h020, 1, 32'hCAFEF00D, 5'd10);
      // address wrap: 0x400 aliases 0x000
      v(0,0, 0,0,1, 2'd2,0, 32'h400, 32'h11111111, 5'd0,  0,0,0, 32'h400, 0, 32'h0,        5'd0);
      v(0,0, 1,1,0, 2'd2,0, 32'h000, 32'h0,        5'd0,  1,1,0, 32'h000, 1, 32'h11111111, 5'd0);
      // flushed store: bubble, memory untouched
      v(0,1, 1,0,1, 2'd2,0, 32'h010, 32'h99999999, 5'd3,  0,0,0, 32'h000, 1, 32'h0,        5'd0);
      v(0,0, 1,1,0, 2'd2,0, 32'h010, 32'h0,        5'd12, 1,1,0, 32'h010, 1, 32'h123455EF, 5'd12);
      // stall: outputs frozen, store lands once after release
      v(0,0, 0,0,1, 2'd2,0, 32'h040, 32'h01020304, 5'd0,  0,0,0, 32'h040, 0, 32'h0,        5'd0);
      v(0,0, 1,1,0, 2'd2,0, 32'h010, 32'h0,        5'd13, 1,1,0, 32'h010, 1, 32'h123455EF, 5'd13);
      v(1,0, 0,0,1, 2'd2,0, 32'h040, 32'hA5A5A5A5, 5'd0,  1,1,0, 32'h010, 1, 32'h123455EF, 5'd13);
      v(1,0, 0,0,1, 2'd2,0, 32'h040, 32'hA5A5A5A5, 5'd0,  1,1,0, 32'h010, 1, 32'h123455EF, 5'd13);
      v(0,0, 0,0,1, 2'd2,0, 32'h040, 32'hA5A5A5A5, 5'd0,  0,0,0, 32'h040, 0, 32'h0,        5'd0);
      v(1,0, 0,0,1, 2'd2,0, 32'h040, 32'h77777777, 5'd0,  0,0,0, 32'h040, 0, 32'h0,        5'd0);
      v(0,0, 1,1,0, 2'd2,0, 32'h040, 32'h0,        5'd14, 1,1,0, 32'h040, 1, 32'hA5A5A5A5, 5'd14);
      // stall and flush together: bubble wins
      v(1,1, 1,1,0, 2'd2,0, 32'h040, 32'h0,        5'd15, 0,0,0, 32'h000, 1, 32'h0,        5'd0);

      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         chk({tag, ".reg_wr_en"},     {31'd0, reg_wr_en},     {31'd0, vecs[i].e_rwe});
         chk({tag, ".mem_to_reg_wr"}, {31'd0, mem_to_reg_wr}, {31'd0, vecs[i].e_m2r});
         chk({tag, ".misalign_err"},  {31'd0, misalign_err},  {31'd0, vecs[i].e_mis});
         chk({tag, ".alu_result"},    alu_result,             vecs[i].e_alu);
         chk({tag, ".reg_wr_addr"},   {27'd0, reg_wr_addr},   {27'd0, vecs[i].e_waddr});
         if (vecs[i].chk_rd)
            chk({tag, ".mem_rd_data"}, mem_rd_data, vecs[i].e_rd);
         @(negedge clk);
      end

      // Reset mid-cycle with a misaligned load sitting in WB
      drive(idle);
      in_reg_wr_en = 1'b1; in_mem_to_reg = 1'b1; in_mem_size = 2'd2;
      in_alu_result = 32'h022; in_reg_wr_addr = 5'd17;
      @(posedge clk);
      #1;
      chk("rst.pre_mis", {31'd0, misalign_err}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk_all_zero("rst.async");
      @(negedge clk);
      rst_n = 1'b1;
      in_alu_result = 32'h010; in_reg_wr_addr = 5'd18;
      @(posedge clk);
      #1;
      chk("rst.after.rd",  mem_rd_data, 32'h123455EF);
      chk("rst.after.rwe", {31'd0, reg_wr_en}, 32'd1);
      chk("rst.after.wa",  {27'd0, reg_wr_addr}, 32'd18);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
